// File: rtl/heartbeat_pacer.sv
// Heartbeat pacer: turns a 2-bit rate code into a timed lub-dub pulse train.
// All timing is counted in prescaled ticks; rate changes only land on beat boundaries.
module heartbeat_pacer #(
    parameter int PRESCALE      = 10000,
    parameter int PERIOD_FAST   = 400,
    parameter int PERIOD_NORMAL = 750,
    parameter int PERIOD_SLOW   = 1200,
    parameter int PULSE_LEN     = 80,
    parameter int GAP_LEN       = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] hb_code,
    output logic       beat_o,
    output logic       beat_strobe,
    output logic [1:0] rate_o,
    output logic       active
);

    localparam int TW       = 11;
    localparam int MIN_BEAT = 2 * PULSE_LEN + GAP_LEN;

    localparam logic [15:0]   PRE_LAST   = 16'(PRESCALE - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_LEN - 1);

    localparam logic [1:0] CODE_NONE = 2'd3;

    // Illegal timing parameters stop elaboration rather than producing a broken beat.
    if (PRESCALE < 1 || PRESCALE > 65536 ||
        PULSE_LEN < 1 || PULSE_LEN >= 2048 ||
        GAP_LEN < 1 || GAP_LEN >= 2048 ||
        PERIOD_FAST   <= MIN_BEAT || PERIOD_FAST   >= 2048 ||
        PERIOD_NORMAL <= MIN_BEAT || PERIOD_NORMAL >= 2048 ||
        PERIOD_SLOW   <= MIN_BEAT || PERIOD_SLOW   >= 2048) begin : g_param_check
        $error("heartbeat_pacer: illegal timing parameters");
    end

    typedef enum logic [2:0] {
        IDLE,
        LUB,
        GAP,
        DUB,
        REST
    } state_t;

    state_t          state;
    logic [15:0]     pre_cnt;
    logic            tick;
    logic [TW-1:0]   phase_tmr;
    logic [TW-1:0]   beat_tmr;

    function automatic logic [TW-1:0] period_last(input logic [1:0] code);
        logic [TW-1:0] p;
        p = TW'(PERIOD_NORMAL - 1);
        case (code)
            2'd0:    p = TW'(PERIOD_FAST - 1);
            2'd2:    p = TW'(PERIOD_SLOW - 1);
            default: p = TW'(PERIOD_NORMAL - 1);
        endcase
        return p;
    endfunction

    assign tick = ena && (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (ena) begin
            pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
        end
    end

    // Whole sequencer freezes with ena low, so a paused beat resumes cycle-exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase_tmr   <= '0;
            beat_tmr    <= '0;
            beat_o      <= 1'b0;
            beat_strobe <= 1'b0;
            rate_o      <= CODE_NONE;
            active      <= 1'b0;
        end else if (ena) begin
            beat_strobe <= 1'b0;
            if (tick) begin
                phase_tmr <= phase_tmr + TW'(1);
                beat_tmr  <= beat_tmr + TW'(1);
                case (state)
                    IDLE: begin
                        phase_tmr <= '0;
                        beat_tmr  <= '0;
                        if (hb_code != CODE_NONE) begin
                            state       <= LUB;
                            beat_o      <= 1'b1;
                            beat_strobe <= 1'b1;
                            rate_o      <= hb_code;
                            active      <= 1'b1;
                        end
                    end
                    LUB: begin
                        if (phase_tmr == PULSE_LAST) begin
                            state     <= GAP;
                            beat_o    <= 1'b0;
                            phase_tmr <= '0;
                        end
                    end
                    GAP: begin
                        if (phase_tmr == GAP_LAST) begin
                            state     <= DUB;
                            beat_o    <= 1'b1;
                            phase_tmr <= '0;
                        end
                    end
                    DUB: begin
                        if (phase_tmr == PULSE_LAST) begin
                            state     <= REST;
                            beat_o    <= 1'b0;
                            phase_tmr <= '0;
                        end
                    end
                    REST: begin
                        // Period is start-to-start, so this tick completes the beat.
                        if (beat_tmr == period_last(rate_o)) begin
                            phase_tmr <= '0;
                            beat_tmr  <= '0;
                            if (hb_code != CODE_NONE) begin
                                state       <= LUB;
                                beat_o      <= 1'b1;
                                beat_strobe <= 1'b1;
                                rate_o      <= hb_code;
                            end else begin
                                state  <= IDLE;
                                rate_o <= CODE_NONE;
                                active <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        beat_o    <= 1'b0;
                        rate_o    <= CODE_NONE;
                        active    <= 1'b0;
                        phase_tmr <= '0;
                        beat_tmr  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_heartbeat_pacer.sv
// Bench for heartbeat_pacer with small timing parameters (4 clk per tick).
// Vector table for steady-rate waveforms plus scoreboarded strobe sequences.
module tb_heartbeat_pacer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [1:0] hb_code = 2'd1;
    logic       beat_o;
    logic       beat_strobe;
    logic [1:0] rate_o;
    logic       active;

    int checks = 0;
    int errors = 0;
    int ecyc = 0;
    bit sb_on = 1'b0;

    typedef struct {
        int         cyc;
        logic [1:0] rate;
    } sb_t;

    sb_t sb_q[$];

    typedef struct {
        logic [1:0] code;
        int         cyc;
        logic       beat;
        logic       strobe;
        logic [1:0] rate;
        logic       act;
    } vec_t;

    heartbeat_pacer #(
        .PRESCALE(4), .PERIOD_FAST(8), .PERIOD_NORMAL(12), .PERIOD_SLOW(16),
        .PULSE_LEN(2), .GAP_LEN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .hb_code(hb_code),
        .beat_o(beat_o), .beat_strobe(beat_strobe), .rate_o(rate_o), .active(active)
    );

    always #5 clk = ~clk;

    // Enabled clock edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecyc <= 0;
        else if (ena) ecyc <= ecyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && sb_on && beat_strobe) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_strobe at ecyc %0d rate %0d", ecyc, rate_o);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.cyc != ecyc || e.rate != rate_o) begin
                    errors++;
                    $display("FAIL sb_strobe got ecyc %0d rate %0d want ecyc %0d rate %0d",
                             ecyc, rate_o, e.cyc, e.rate);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at ecyc %0d got %0d want %0d", nm, ecyc, act, exp);
        end
    endtask

    task automatic chk_q(input string nm);
        chk({nm, "_pending_strobes"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic push(input int c, input logic [1:0] r);
        sb_t e;
        e.cyc  = c;
        e.rate = r;
        sb_q.push_back(e);
    endtask

    task automatic apply_reset(input logic [1:0] code);
        rst_n = 1'b0;
        ena = 1'b1;
        hb_code = code;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ecyc(input int k);
        int guard = 0;
        while (ecyc < k && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (ecyc < k) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for ecyc got %0d want %0d", ecyc, k);
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{2'd1,   0, 1'b0, 1'b0, 2'd3, 1'b0},
            '{2'd1,   3, 1'b0, 1'b0, 2'd3, 1'b0},
            '{2'd1,   4, 1'b1, 1'b1, 2'd1, 1'b1},
            '{2'd1,   5, 1'b1, 1'b0, 2'd1, 1'b1},
            '{2'd1,  11, 1'b1, 1'b0, 2'd1, 1'b1},
            '{2'd1,  12, 1'b0, 1'b0, 2'd1, 1'b1},
            '{2'd1,  15, 1'b0, 1'b0, 2'd1, 1'b1},
            '{2'd1,  16, 1'b1, 1'b0, 2'd1, 1'b1},
            '{2'd1,  23, 1'b1, 1'b0, 2'd1, 1'b1},
            '{2'd1,  24, 1'b0, 1'b0, 2'd1, 1'b1},
            '{2'd1,  51, 1'b0, 1'b0, 2'd1, 1'b1},
            '{2'd1,  52, 1'b1, 1'b1, 2'd1, 1'b1},
            '{2'd1,  53, 1'b1, 1'b0, 2'd1, 1'b1},
            '{2'd0,  24, 1'b0, 1'b0, 2'd0, 1'b1},
            '{2'd0,  35, 1'b0, 1'b0, 2'd0, 1'b1},
            '{2'd0,  36, 1'b1, 1'b1, 2'd0, 1'b1},
            '{2'd2,  67, 1'b0, 1'b0, 2'd2, 1'b1},
            '{2'd2,  68, 1'b1, 1'b1, 2'd2, 1'b1},
            '{2'd3,   0, 1'b0, 1'b0, 2'd3, 1'b0},
            '{2'd3,   4, 1'b0, 1'b0, 2'd3, 1'b0},
            '{2'd3, 200, 1'b0, 1'b0, 2'd3, 1'b0}
        };

        foreach (vecs[i]) begin
            apply_reset(vecs[i].code);
            wait_ecyc(vecs[i].cyc);
            chk($sformatf("vec%0d_beat", i),   beat_o,      vecs[i].beat);
            chk($sformatf("vec%0d_strobe", i), beat_strobe, vecs[i].strobe);
            chk($sformatf("vec%0d_rate", i),   rate_o,      vecs[i].rate);
            chk($sformatf("vec%0d_active", i), active,      vecs[i].act);
        end

        sb_on = 1'b1;

        // Idle code from reset: nothing moves for 200 clk.
        begin
            int bad = 0;
            sb_q.delete();
            apply_reset(2'd3);
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (beat_o || active || beat_strobe || rate_o != 2'd3) bad = 1;
            end
            chk("idle_quiet", bad, 0);
            chk_q("idle");
        end

        // Normal -> fast during the first lub: first period kept, then 32 clk.
        apply_reset(2'd1);
        push(4, 2'd1); push(52, 2'd0); push(84, 2'd0); push(116, 2'd0);
        wait_ecyc(6);
        hb_code = 2'd0;
        wait_ecyc(120);
        chk_q("normal_to_fast");

        // Code none during the gap: dub and rest still complete, then idle.
        apply_reset(2'd1);
        push(4, 2'd1);
        wait_ecyc(13);
        hb_code = 2'd3;
        wait_ecyc(20);  chk("gap_stop_dub_high", beat_o, 1);
        wait_ecyc(24);  chk("gap_stop_dub_end", beat_o, 0);
        wait_ecyc(51);  chk("gap_stop_rest_active", active, 1);
        chk("gap_stop_rest_rate", rate_o, 1);
        wait_ecyc(52);  chk("gap_stop_idle_active", active, 0);
        chk("gap_stop_idle_rate", rate_o, 3);
        chk("gap_stop_idle_beat", beat_o, 0);
        wait_ecyc(150); chk("gap_stop_late_active", active, 0);
        chk_q("gap_stop");

        // Slow beat in rest while fast is selected: slow period finishes first.
        apply_reset(2'd2);
        push(4, 2'd2); push(68, 2'd0); push(100, 2'd0);
        wait_ecyc(30);
        hb_code = 2'd0;
        wait_ecyc(105);
        chk_q("slow_to_fast");

        // ena low for 20 clk mid-dub: waveform holds, enabled-cycle timing unchanged.
        apply_reset(2'd1);
        push(4, 2'd1); push(52, 2'd1); push(100, 2'd1);
        wait_ecyc(18);
        ena = 1'b0;
        begin
            int low = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (beat_o !== 1'b1 || active !== 1'b1) low++;
            end
            chk("ena_hold_beat", low, 0);
        end
        chk("ena_hold_ecyc", ecyc, 18);
        ena = 1'b1;
        wait_ecyc(23);  chk("ena_dub_still_high", beat_o, 1);
        wait_ecyc(24);  chk("ena_dub_end", beat_o, 0);
        wait_ecyc(110);
        chk_q("ena_pause");

        // Async reset mid-lub, then restart with the same 4-clk latency.
        apply_reset(2'd1);
        push(4, 2'd1);
        wait_ecyc(6);
        chk("rst_pre_beat", beat_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_beat", beat_o, 0);
        chk("rst_async_active", active, 0);
        chk("rst_async_rate", rate_o, 3);
        chk_q("rst_first");
        push(4, 2'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ecyc(3);   chk("rst_again_pre", beat_o, 0);
        wait_ecyc(4);   chk("rst_again_rise", beat_o, 1);
        wait_ecyc(10);
        chk_q("rst_again");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/heartbeat_pacer.md
Name: heartbeat_pacer

Overview:
- Sequencer that turns the 2-bit heartbeat rate code (0 fast, 1 normal, 2 slow, 3 none) into a timed "lub-dub" pulse train for the mimosa's heartbeat LED/output pin.
- Sits downstream of the heartbeat rate encoder, ahead of the output mux.
- Rate changes are applied only on beat boundaries, so a beat is never truncated or stretched mid-pulse.

Parameters:
- PRESCALE, 10000: clk cycles per timing tick (1 ms at 10 MHz); 16-bit prescaler.
- PERIOD_FAST, 400: ticks from one beat start to the next, code 0.
- PERIOD_NORMAL, 750: ticks per beat, code 1.
- PERIOD_SLOW, 1200: ticks per beat, code 2.
- PULSE_LEN, 80: ticks per lub and per dub high phase.
- GAP_LEN, 60: ticks low between lub and dub.
- Constraint: every PERIOD_* > 2*PULSE_LEN + GAP_LEN, all ≥ 1, all < 2048 (11-bit tick counter). Violation is flagged by an elaboration-time check.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; low freezes prescaler, FSM and all counters (outputs hold)
- hb_code  input  2  heartbeat rate code
- beat_o  output  1  heartbeat waveform; high during lub and dub
- beat_strobe  output  1  one clk cycle high in the first cycle beat_o is high for each lub
- rate_o  output  2  code latched for the beat in progress; 3 when idle
- active  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, prescaler=0, tick counter=0.
  - beat_o=0, beat_strobe=0, rate_o=3, active=0.
  - Takes effect immediately, including mid-beat.
  - First clk edge with rst_n=1 and ena=1 counts as prescaler cycle 0.
- Prescaler:
  - Counts 0..PRESCALE-1 on clk when ena=1 and wraps.
  - tick=1 in the cycle the count is PRESCALE-1.
  - Free-running in all FSM states.
- States: IDLE, LUB, GAP, DUB, REST. All transitions occur on a clk edge where tick=1.
  - IDLE: on tick, if hb_code≠3 → LUB. Latch rate_o=hb_code, load beat-timer=0, assert beat_strobe for the next cycle. If hb_code=3, stay.
  - LUB: beat_o=1. After PULSE_LEN ticks → GAP.
  - GAP: beat_o=0. After GAP_LEN ticks → DUB.
  - DUB: beat_o=1. After PULSE_LEN ticks → REST.
  - REST: beat_o=0. Leaves when the beat-timer reaches PERIOD(rate_o) ticks since LUB entry:
    - hb_code≠3 → LUB with the new rate latched, beat_strobe pulse, timer reset.
    - hb_code=3 → IDLE, rate_o=3.
- Timing:
  - Beat-timer counts every tick from LUB entry; the period is measured start-to-start.
  - Phase timer restarts at each phase entry.
- Outputs are registered; beat_o and beat_strobe are glitch-free.
- Boundary cases:
  - hb_code changes during LUB/GAP/DUB/REST: ignored until the REST exit decision.
  - hb_code=3 mid-beat: current beat completes fully, then IDLE.
  - ena low mid-phase: all state holds; timing resumes exactly where it stopped, with no extra or lost tick.
  - Faster code selected while a slow beat is in REST: the slow period still completes first.

Test Plan (PRESCALE=4, PULSE_LEN=2, GAP_LEN=1, PERIOD_FAST=8, PERIOD_NORMAL=12, PERIOD_SLOW=16):
- Release reset with hb_code=1, ena=1.
  - beat_o rises 4 clk after release; beat_strobe high that same cycle only.
  - beat_o high 8 clk, low 4, high 8, low 28; next rise 48 clk after the first; rate_o=1.
- hb_code=3 from reset: beat_o, beat_strobe and active stay 0 and rate_o=3 for 200 clk.
- hb_code switched 1→0 during the first LUB:
  - First beat keeps a 48-clk period.
  - Subsequent rises every 32 clk; rate_o changes to 0 in the same cycle as the second beat_strobe.
- hb_code switched to 3 during GAP: DUB still occurs (8 clk high), REST completes, then active=0 and rate_o=3 with no further beat_strobe.
- ena held low 20 clk in the middle of DUB: beat_o stays 1 throughout; DUB total high time is 8 enabled clk; the period measured in enabled cycles is unchanged.
- rst_n pulsed low mid-LUB: beat_o=0, active=0, rate_o=3 immediately (async); after release the first rise again comes 4 clk later.
